// File: rtl/duk_sd_pkg.sv
// duk_sd_pkg: shared constants and types for the duk sigma-delta back end.
// Contents:
//   OSR_LOG2_DEF  default log2 of the decimation ratio
//   out_w()       result width for a given OSR_LOG2 (2*OSR_LOG2+1)
//   SINC_MODE     decimator order; SINC2 when DUK_SD_SINC2_EN is defined
//   settle_e      settling states of the sinc2 output path
package duk_sd_pkg;

  localparam int unsigned OSR_LOG2_DEF = 4;

  function automatic int unsigned out_w(input int unsigned osr_log2);
    return 2 * osr_log2 + 1;
  endfunction

  typedef enum logic {
    SINC1 = 1'b0,
    SINC2 = 1'b1
  } sinc_mode_e;

`ifdef DUK_SD_SINC2_EN
  localparam sinc_mode_e SINC_MODE = SINC2;
`else
  localparam sinc_mode_e SINC_MODE = SINC1;
`endif

  typedef enum logic [1:0] {
    SETTLE_0 = 2'd0,
    SETTLE_1 = 2'd1,
    SETTLED  = 2'd2
  } settle_e;

endpackage

// File: rtl/duk_sd_decimator_if.sv
// duk_sd_decimator_if: valid/ready result channel of the duk decimator.
// Signals:
//   res_data   decimated result (OUT_W bits)
//   res_valid  res_data holds an unconsumed result
//   res_ready  consumer accepts res_data when high together with res_valid
// Modports: master (decimator side), slave (consumer side).
interface duk_sd_decimator_if
  import duk_sd_pkg::*;
#(
  parameter int unsigned OUT_W = out_w(OSR_LOG2_DEF)
);
  logic [OUT_W-1:0] res_data;
  logic             res_valid;
  logic             res_ready;

  modport master (output res_data, output res_valid, input res_ready);
  modport slave  (input res_data, input res_valid, output res_ready);
endinterface

// File: rtl/duk_sync2.sv
// duk_sync2: generic 2-flop synchroniser, asynchronous active-low reset.
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset (clears both stages)
//   d      asynchronous input
//   q      synchronised output, two clk edges behind d
module duk_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/duk_sd_decimator.sv
// duk_sd_decimator: digital back end of the duk first-order sigma-delta
// modulator. Synchronises the comparator stream, drives the feedback DAC
// switch, decimates by M = 2^OSR_LOG2 and hands results out through a
// single-entry valid/ready register.
// Build option: DUK_SD_SINC2_EN selects a sinc2 decimator (0..M^2, two
// settling frames suppressed); undefined gives sinc1 (0..M, upper bits 0).
// Ports:
//   clk      single clock
//   rst_n    asynchronous active-low reset
//   ena      design enable; low behaves as run=0
//   run      conversion enable (level)
//   cmp_in   comparator bit, asynchronous to clk
//   fb_out   feedback DAC switch drive
//   res      result channel (res_data/res_valid/res_ready), master side
//   res_ovr  sticky overrun flag, cleared on the falling edge of run
module duk_sd_decimator
  import duk_sd_pkg::*;
#(
  parameter int unsigned OSR_LOG2 = OSR_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 run,
  input  logic                 cmp_in,
  output logic                 fb_out,
  duk_sd_decimator_if.master   res,
  output logic                 res_ovr
);
  localparam int unsigned OUT_W = out_w(OSR_LOG2);

  logic             cmp_s;
  logic             active;
  logic             bit_in;
  logic [OSR_LOG2-1:0] frame_cnt;
  logic             frame_end;
  logic [OUT_W-1:0] result;
  logic             result_ok;
  logic [OUT_W-1:0] data_q;
  logic             valid_q;
  logic             run_q;
  logic             run_fall;

  duk_sync2 #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (cmp_s)
  );

  assign active = run & ena;
  // The bit loaded into fb_out this edge is the bit counted this edge, so
  // the first counted bit is the fb_out registered on the first active edge.
  assign bit_in    = active & cmp_s;
  assign frame_end = active && (frame_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_out    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      fb_out <= bit_in;
      if (!active) frame_cnt <= '0;
      else         frame_cnt <= frame_cnt + 1'b1;
    end
  end

`ifdef DUK_SD_SINC2_EN
  logic [OUT_W-1:0] i1, i2, i2_prev, d_prev;
  logic [OUT_W-1:0] i1_next, i2_next, diff;
  settle_e          st, st_next;

  always_comb begin
    i1_next = i1 + OUT_W'(bit_in);
    i2_next = i2 + i1_next;
    diff    = i2_next - i2_prev;
    result  = diff - d_prev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1      <= '0;
      i2      <= '0;
      i2_prev <= '0;
      d_prev  <= '0;
    end else if (!active) begin
      i1      <= '0;
      i2      <= '0;
      i2_prev <= '0;
      d_prev  <= '0;
    end else begin
      i1 <= i1_next;
      i2 <= i2_next;
      if (frame_end) begin
        i2_prev <= i2_next;
        d_prev  <= diff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= SETTLE_0;
    else        st <= st_next;
  end

  always_comb begin
    st_next   = st;
    result_ok = 1'b0;
    if (!active) begin
      st_next = SETTLE_0;
    end else if (frame_end) begin
      case (st)
        SETTLE_0: st_next = SETTLE_1;
        SETTLE_1: st_next = SETTLED;
        SETTLED:  result_ok = 1'b1;
        default:  st_next = SETTLE_0;
      endcase
    end
  end
`else
  logic [OSR_LOG2:0] ones, ones_next;

  assign ones_next = ones + {{OSR_LOG2{1'b0}}, bit_in};
  assign result    = {{(OUT_W-OSR_LOG2-1){1'b0}}, ones_next};
  assign result_ok = frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ones <= '0;
    else if (!active || frame_end) ones <= '0;
    else                           ones <= ones_next;
  end
`endif

  assign run_fall = run_q & ~run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      res_ovr <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      run_q <= run;
      if (result_ok) begin
        data_q  <= result;
        valid_q <= 1'b1;
      end else if (valid_q && res.res_ready) begin
        valid_q <= 1'b0;
      end
      if (run_fall)                                      res_ovr <= 1'b0;
      else if (result_ok && valid_q && !res.res_ready)   res_ovr <= 1'b1;
    end
  end

  assign res.res_data  = data_q;
  assign res.res_valid = valid_q;
endmodule

// File: doc/duk_sd_decimator.md
# duk_sd_decimator

Digital back end for the duk opamp macro configured as a first-order sigma-delta modulator. The opamp integrator and comparator deliver a 1-bit stream on a dedicated input pin. This block does four things:
- synchronises that stream;
- drives the 1-bit feedback DAC switch;
- decimates the stream by 2^OSR_LOG2;
- presents each result through a single-entry valid/ready output register for the TT digital I/O.

## Interface
Parameters:
- OSR_LOG2, default 4: decimation ratio M = 2^OSR_LOG2; legal range 2..7.
- OUT_W, default 2*OSR_LOG2+1: result width; fixed by formula, not overridable.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset; deassertion synchronised externally.
- ena  in  1  TT design enable; when low, block behaves as run=0.
- run  in  1  conversion enable, level-sensitive.
- cmp_in  in  1  comparator output from the opamp stage; asynchronous to clk.
- fb_out  out  1  feedback DAC switch drive to the opamp stage.
- res_data  out  OUT_W  decimated result.
- res_valid  out  1  res_data holds an unconsumed result.
- res_ready  in  1  consumer accepts res_data when high with res_valid.
- res_ovr  out  1  sticky overrun flag.

## Operation
- cmp_in passes a 2-FF synchroniser producing cmp_s.
- fb_out <= cmp_s every cycle while active; 0 while inactive. "Active" = run & ena.
- The counted bit is fb_out, i.e. the value actually fed back.
- Frame counter: OSR_LOG2 bits, counts 0..M-1 while active. Frame end = counter at M-1.
- Sinc1 (default): ones-counter, OSR_LOG2+1 bits.
  - Adds fb_out each active cycle.
  - At frame end, result = count including the frame-end bit, zero-extended to OUT_W. Counter then restarts at 0.
  - Range 0..M.
- Sinc2 (macro set): integrators i1 and i2, both OUT_W bits, modular arithmetic.
  - Each active cycle: i1 += fb_out, then i2 += i1 (new i1).
  - At frame end: d = i2 − i2_prev, result = d − d_prev. Then update i2_prev and d_prev.
  - Range 0..M².
  - The first two frame ends after activation produce no result (settling).
- Result hand-off at frame end:
  - If res_valid = 0, or res_ready = 1 in the same cycle: load res_data and set res_valid.
  - Otherwise overwrite res_data with the newest result, keep res_valid = 1, and set res_ovr.
- A transfer occurs in any cycle where res_valid & res_ready. It clears res_valid unless a new result loads in that same cycle.
- res_ovr clears only on the cycle run falls, or on reset.
- Run deassert mid-frame:
  - Frame counter, ones-counter, integrators, history registers and settling count all clear on the next edge. The partial frame is discarded.
  - res_data/res_valid are retained until consumed.

## Timing
- Reset values:
  - fb_out = 0, res_data = 0, res_valid = 0, res_ovr = 0.
  - All counters, integrators and the synchroniser clear.
- cmp_in to fb_out: 3 clk edges (2 sync + 1 register).
- Activation: the first counted bit is the fb_out registered on the first active edge. Sinc1 first result appears M cycles after run rises; sinc2 first result after 3M cycles.
- res_valid rises the cycle after the frame-end edge, i.e. result registered on the frame-end edge.
- Reset asserted mid-frame: all state clears immediately (async). No partial result is emitted.

## Configuration
- DUK_SD_SINC2_EN defined: sinc2 path compiled in; results span 0..M² across the full OUT_W bits; 2-frame settling suppression.
- Not defined: sinc1 only; upper OUT_W−(OSR_LOG2+1) bits of res_data tie to 0; no settling suppression.
- Port list identical in both builds.

## Structure
- Package duk_sd_pkg:
  - OSR_LOG2 default constant;
  - OUT_W width function;
  - sinc-mode localparam derived from the macro.
- Sub-module duk_sync2: generic 2-FF synchroniser with async active-low reset, reused for cmp_in.
- Decimator, frame counter and output register are inline in duk_sd_decimator.

## Test plan
All scenarios use OSR_LOG2=4 (M=16).
- Sinc1, cmp_in held 1, run=1, res_ready=1 → every frame res_data=16, one res_valid pulse every 16 cycles, fb_out=1 from the 3rd edge.
- Sinc1, cmp_in toggling each cycle → res_data=8 every frame. Sinc2 build with cmp_in held 1 → first two frames suppressed, then res_data=256. Sinc2 with cmp_in toggling → res_data=128.
- res_ready held 0 for 3 frames with cmp_in=0 → res_valid stays 1, res_data=0 (latest), res_ovr=1. Then res_ready=1 for one cycle → res_valid=0; res_ovr stays 1 until run falls.
- Transfer and new result in the same cycle → res_valid stays 1 with the new data; res_ovr unchanged.
- run dropped at frame count 9, then restored → no result for the partial frame. The next result arrives 16 cycles after re-enable and reflects only the new frame.
- rst_n pulsed low mid-frame with res_valid=1 → all outputs 0 immediately, first post-reset result after M cycles of run (3M in sinc2).
